// File: rtl/lift_motion_ctrl.sv
// Car-side motion controller for a 3-floor lift: collective up/down scheduling,
// floor travel and door dwell paced by the shared slowref tick.
module lift_motion_ctrl #(
  parameter int unsigned FLOOR_TICKS = 4,
  parameter int unsigned DOOR_TICKS  = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       slowref,
  input  logic [2:0] upreq,
  input  logic [2:0] dnreq,
  input  logic [2:0] flreq,
  output logic       upsig,
  output logic       dnsig,
  output logic       moving,
  output logic [1:0] floorno,
  output logic       door_open,
  output logic [2:0] clrup,
  output logic [2:0] clrdn,
  output logic [2:0] clr_flreq
);

  typedef enum logic [1:0] {S_IDLE, S_MOVE_UP, S_MOVE_DN, S_DOOR} state_t;

  localparam logic [7:0] L_FLOOR_LAST = 8'(FLOOR_TICKS - 1);
  localparam logic [7:0] L_DOOR_LAST  = 8'(DOOR_TICKS - 1);

  state_t     r_state;
  logic       r_dirup;
  logic [7:0] r_cnt;
  logic [1:0] r_floor;
  logic       r_upsig, r_dnsig, r_door;
  logic [2:0] r_clrup, r_clrdn, r_clr_fl;

  function automatic logic [2:0] f_onehot(input logic [1:0] f);
    case (f)
      2'd0:    return 3'b001;
      2'd1:    return 3'b010;
      2'd2:    return 3'b100;
      default: return 3'b000;
    endcase
  endfunction

  function automatic logic [2:0] f_above(input logic [1:0] f);
    case (f)
      2'd0:    return 3'b110;
      2'd1:    return 3'b100;
      default: return 3'b000;
    endcase
  endfunction

  function automatic logic [2:0] f_below(input logic [1:0] f);
    case (f)
      2'd1:    return 3'b001;
      2'd2:    return 3'b011;
      default: return 3'b000;
    endcase
  endfunction

  logic [2:0] w_upm, w_dnm, w_pend;
  logic [1:0] w_f_up, w_f_dn;
  logic [2:0] w_oh_cur, w_oh_up, w_oh_dn;
  logic       w_pend_here, w_above, w_below, w_ahead_up, w_behind_dn;
  logic       w_up_stop, w_dn_stop;

  // Up calls cannot exist at the top floor, nor down calls at the bottom.
  assign w_upm  = upreq & 3'b011;
  assign w_dnm  = dnreq & 3'b110;
  assign w_pend = flreq | w_upm | w_dnm;

  assign w_f_up   = r_floor + 2'd1;
  assign w_f_dn   = r_floor - 2'd1;
  assign w_oh_cur = f_onehot(r_floor);
  assign w_oh_up  = f_onehot(w_f_up);
  assign w_oh_dn  = f_onehot(w_f_dn);

  assign w_pend_here = |(w_pend & w_oh_cur);
  assign w_above     = |(w_pend & f_above(r_floor));
  assign w_below     = |(w_pend & f_below(r_floor));
  assign w_ahead_up  = |(w_pend & f_above(w_f_up));
  assign w_behind_dn = |(w_pend & f_below(w_f_dn));

  assign w_up_stop = (|((flreq | w_upm) & w_oh_up)) | w_oh_up[2]
                   | ((|(w_dnm & w_oh_up)) & !w_ahead_up);
  assign w_dn_stop = (|((flreq | w_dnm) & w_oh_dn)) | w_oh_dn[0]
                   | ((|(w_upm & w_oh_dn)) & !w_behind_dn);

  // Floor and direction the door would open with if DOOR were entered this clk.
  logic [2:0] w_door_oh, w_door_clrup, w_door_clrdn;
  logic       w_door_dir;

  always_comb begin
    // NOTE: every signal gets a default first so no path through the case infers a latch.
    w_door_oh  = w_oh_cur;
    w_door_dir = r_dirup;
    case (r_state)
      S_IDLE: begin
        if (|(w_upm & w_oh_cur))      w_door_dir = 1'b1;
        else if (|(w_dnm & w_oh_cur)) w_door_dir = 1'b0;
      end
      S_MOVE_UP: begin
        w_door_oh = w_oh_up;
        if (!(|(w_upm & w_oh_up)) && !w_ahead_up) w_door_dir = 1'b0;
      end
      S_MOVE_DN: begin
        w_door_oh = w_oh_dn;
        if (!(|(w_dnm & w_oh_dn)) && !w_behind_dn) w_door_dir = 1'b1;
      end
      default: ;
    endcase
  end

  assign w_door_clrup = w_door_dir ? (w_door_oh & 3'b011) : 3'b000;
  assign w_door_clrdn = w_door_dir ? 3'b000 : (w_door_oh & 3'b110);

  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      r_state  <= S_IDLE;
      r_dirup  <= 1'b1;
      r_cnt    <= '0;
      r_floor  <= '0;
      r_upsig  <= 1'b0;
      r_dnsig  <= 1'b0;
      r_door   <= 1'b0;
      r_clrup  <= '0;
      r_clrdn  <= '0;
      r_clr_fl <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_cnt <= '0;
          if (w_pend_here) begin
            r_state  <= S_DOOR;
            r_dirup  <= w_door_dir;
            r_door   <= 1'b1;
            r_clr_fl <= w_door_oh;
            r_clrup  <= w_door_clrup;
            r_clrdn  <= w_door_clrdn;
          end else if (r_dirup && w_above) begin
            r_state <= S_MOVE_UP;
            r_upsig <= 1'b1;
          end else if (w_below) begin
            r_state <= S_MOVE_DN;
            r_dirup <= 1'b0;
            r_dnsig <= 1'b1;
          end else if (w_above) begin
            r_state <= S_MOVE_UP;
            r_dirup <= 1'b1;
            r_upsig <= 1'b1;
          end
        end

        S_MOVE_UP, S_MOVE_DN: begin
          if (slowref) begin
            if (r_cnt == L_FLOOR_LAST) begin
              r_cnt   <= '0;
              r_floor <= (r_state == S_MOVE_UP) ? w_f_up : w_f_dn;
              if ((r_state == S_MOVE_UP) ? w_up_stop : w_dn_stop) begin
                r_state  <= S_DOOR;
                r_dirup  <= w_door_dir;
                r_upsig  <= 1'b0;
                r_dnsig  <= 1'b0;
                r_door   <= 1'b1;
                r_clr_fl <= w_door_oh;
                r_clrup  <= w_door_clrup;
                r_clrdn  <= w_door_clrdn;
              end
            end else begin
              r_cnt <= r_cnt + 8'd1;
            end
          end
        end

        S_DOOR: begin
          if (slowref) begin
            if (r_cnt == L_DOOR_LAST) begin
              r_state  <= S_IDLE;
              r_cnt    <= '0;
              r_door   <= 1'b0;
              r_clr_fl <= '0;
              r_clrup  <= '0;
              r_clrdn  <= '0;
            end else begin
              r_cnt <= r_cnt + 8'd1;
            end
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign upsig     = r_upsig;
  assign dnsig     = r_dnsig;
  assign moving    = r_upsig | r_dnsig;
  assign floorno   = r_floor;
  assign door_open = r_door;
  assign clrup     = r_clrup;
  assign clrdn     = r_clrdn;
  assign clr_flreq = r_clr_fl;

endmodule

// File: tb/tb_lift_motion_ctrl.sv
// Directed bench for lift_motion_ctrl: FLOOR_TICKS=4, DOOR_TICKS=3, slowref one clk in four.
module tb_lift_motion_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       slowref;
  logic [2:0] upreq, dnreq, flreq;
  logic       upsig, dnsig, moving, door_open;
  logic [1:0] floorno;
  logic [2:0] clrup, clrdn, clr_flreq;

  int n_cmp = 0;
  int n_err = 0;

  lift_motion_ctrl #(.FLOOR_TICKS(4), .DOOR_TICKS(3)) dut (
    .clk       (clk),
    .reset     (reset),
    .slowref   (slowref),
    .upreq     (upreq),
    .dnreq     (dnreq),
    .flreq     (flreq),
    .upsig     (upsig),
    .dnsig     (dnsig),
    .moving    (moving),
    .floorno   (floorno),
    .door_open (door_open),
    .clrup     (clrup),
    .clrdn     (clrdn),
    .clr_flreq (clr_flreq)
  );

  always #5 clk = ~clk;

  // slowref changes on the falling edge, high for one full clk in every four.
  initial begin
    int ph;
    ph = 0;
    slowref = 1'b0;
    forever begin
      @(negedge clk);
      ph = (ph + 1) % 4;
      slowref = (ph == 3);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not reach its summary");
    $fatal(1, "timeout");
  end

  // {upsig, dnsig, moving, door_open, floorno, clrup, clrdn, clr_flreq}
  logic [14:0] outv;
  assign outv = {upsig, dnsig, moving, door_open, floorno, clrup, clrdn, clr_flreq};

  function automatic logic [14:0] mk(input logic up, input logic dn, input logic mv,
                                     input logic door, input logic [1:0] fl,
                                     input logic [2:0] cu, input logic [2:0] cd,
                                     input logic [2:0] cf);
    return {up, dn, mv, door, fl, cu, cd, cf};
  endfunction

  task automatic chk(input string tag, input logic [14:0] obs, input logic [14:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic clk_n(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      forever begin
        @(posedge clk);
        if (slowref) break;
      end
    end
    #1;
  endtask

  initial begin
    logic act;
    reset = 1'b1;
    upreq = '0;
    dnreq = '0;
    flreq = '0;

    // Reset and quiet idle
    clk_n(16);
    chk("reset", outv, mk(0, 0, 0, 0, 2'd0, 3'b000, 3'b000, 3'b000));
    reset = 1'b0;
    act = 1'b0;
    for (int i = 0; i < 200; i++) begin
      clk_n(1);
      if (outv !== 15'd0) act = 1'b1;
    end
    chk("idle200", {14'd0, act}, 15'd0);

    // Car call to floor 2 from floor 0, passing floor 1
    flreq = 3'b100;
    clk_n(1);
    chk("t2_start", outv, mk(1, 0, 1, 0, 2'd0, 3'b000, 3'b000, 3'b000));
    tick(3);
    chk("t2_tick3", outv, mk(1, 0, 1, 0, 2'd0, 3'b000, 3'b000, 3'b000));
    tick(1);
    chk("t2_tick4", outv, mk(1, 0, 1, 0, 2'd1, 3'b000, 3'b000, 3'b000));
    tick(4);
    chk("t2_arrive", outv, mk(0, 0, 0, 1, 2'd2, 3'b000, 3'b100, 3'b100));
    flreq = 3'b000;
    tick(2);
    chk("t2_door2", outv, mk(0, 0, 0, 1, 2'd2, 3'b000, 3'b100, 3'b100));
    tick(1);
    chk("t2_idle", outv, mk(0, 0, 0, 0, 2'd2, 3'b000, 3'b000, 3'b000));
    clk_n(40);
    chk("t2_rest", outv, mk(0, 0, 0, 0, 2'd2, 3'b000, 3'b000, 3'b000));

    // Up and down calls at floor 1 while at floor 2: down served first
    dnreq = 3'b010;
    upreq = 3'b010;
    clk_n(1);
    chk("t4_start", outv, mk(0, 1, 1, 0, 2'd2, 3'b000, 3'b000, 3'b000));
    tick(4);
    chk("t4_arrive", outv, mk(0, 0, 0, 1, 2'd1, 3'b000, 3'b010, 3'b010));
    dnreq = 3'b000;
    tick(3);
    chk("t4_idle", outv, mk(0, 0, 0, 0, 2'd1, 3'b000, 3'b000, 3'b000));
    clk_n(1);
    chk("t4_door2", outv, mk(0, 0, 0, 1, 2'd1, 3'b010, 3'b000, 3'b010));
    upreq = 3'b000;
    tick(3);
    chk("t4_idle2", outv, mk(0, 0, 0, 0, 2'd1, 3'b000, 3'b000, 3'b000));
    clk_n(40);
    chk("t4_rest", outv, mk(0, 0, 0, 0, 2'd1, 3'b000, 3'b000, 3'b000));

    // Car call down to floor 0: direction flips up at the bottom
    flreq = 3'b001;
    clk_n(1);
    chk("dn0_start", outv, mk(0, 1, 1, 0, 2'd1, 3'b000, 3'b000, 3'b000));
    tick(4);
    chk("dn0_arrive", outv, mk(0, 0, 0, 1, 2'd0, 3'b001, 3'b000, 3'b001));
    flreq = 3'b000;
    tick(3);
    chk("dn0_idle", outv, mk(0, 0, 0, 0, 2'd0, 3'b000, 3'b000, 3'b000));

    // Up hall call at the current floor opens the door next clk
    upreq = 3'b001;
    clk_n(1);
    chk("t5_door", outv, mk(0, 0, 0, 1, 2'd0, 3'b001, 3'b000, 3'b001));
    upreq = 3'b000;
    tick(3);
    chk("t5_idle", outv, mk(0, 0, 0, 0, 2'd0, 3'b000, 3'b000, 3'b000));

    // Two car calls: stop at 1 keeping direction up, then continue to 2
    flreq = 3'b110;
    clk_n(1);
    chk("t3_start", outv, mk(1, 0, 1, 0, 2'd0, 3'b000, 3'b000, 3'b000));
    tick(4);
    chk("t3_stop1", outv, mk(0, 0, 0, 1, 2'd1, 3'b010, 3'b000, 3'b010));
    flreq = 3'b100;
    tick(3);
    chk("t3_idle1", outv, mk(0, 0, 0, 0, 2'd1, 3'b000, 3'b000, 3'b000));
    clk_n(1);
    chk("t3_resume", outv, mk(1, 0, 1, 0, 2'd1, 3'b000, 3'b000, 3'b000));
    tick(4);
    chk("t3_stop2", outv, mk(0, 0, 0, 1, 2'd2, 3'b000, 3'b100, 3'b100));
    flreq = 3'b000;
    tick(3);
    chk("t3_idle2", outv, mk(0, 0, 0, 0, 2'd2, 3'b000, 3'b000, 3'b000));

    // Reset from idle at floor 2, then reset mid-travel
    reset = 1'b1;
    #1;
    chk("t6_rst_idle", outv, mk(0, 0, 0, 0, 2'd0, 3'b000, 3'b000, 3'b000));
    clk_n(2);
    reset = 1'b0;
    flreq = 3'b010;
    clk_n(1);
    chk("t6_start", outv, mk(1, 0, 1, 0, 2'd0, 3'b000, 3'b000, 3'b000));
    tick(2);
    #2;
    reset = 1'b1;
    #1;
    chk("t6_rst_mid", outv, mk(0, 0, 0, 0, 2'd0, 3'b000, 3'b000, 3'b000));
    clk_n(3);
    reset = 1'b0;
    clk_n(1);
    chk("t6_restart", outv, mk(1, 0, 1, 0, 2'd0, 3'b000, 3'b000, 3'b000));
    tick(3);
    chk("t6_tick3", outv, mk(1, 0, 1, 0, 2'd0, 3'b000, 3'b000, 3'b000));
    tick(1);
    chk("t6_arrive", outv, mk(0, 0, 0, 1, 2'd1, 3'b000, 3'b010, 3'b010));
    flreq = 3'b000;
    tick(3);
    chk("t6_idle", outv, mk(0, 0, 0, 0, 2'd1, 3'b000, 3'b000, 3'b000));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/lift_motion_ctrl.md
Name: lift_motion_ctrl

Overview:
- Car-side controller for the 3-floor lift. It consumes latched hall calls and car (floor) requests from the request/display block.
- It produces the signals that block expects from the car: upsig, dnsig, moving, floorno, and the clrup/clrdn/clr_flreq clears.
- Travel and door timing are paced by the shared slowref enable tick.
- Collective scheduling: keep direction while requests lie ahead, stop at qualifying floors, reverse when none remain.

Parameters:
FLOOR_TICKS, 4, slowref ticks to travel one floor (1..255)
DOOR_TICKS, 3, slowref ticks the door stays open (1..255)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
slowref  in  1  one-clk enable tick from the slow reference divider
upreq  in  3  latched up hall calls per floor; bit2 ignored
dnreq  in  3  latched down hall calls per floor; bit0 ignored
flreq  in  3  latched car floor requests per floor
upsig  out  1  car travelling up
dnsig  out  1  car travelling down
moving  out  1  upsig | dnsig
floorno  out  2  current floor 0..2
door_open  out  1  door open at floorno
clrup  out  3  clear up call at floor; bit2 always 0
clrdn  out  3  clear down call at floor; bit0 always 0
clr_flreq  out  3  clear car request at floor

Behaviour:
- Reset values (async): all outputs 0, floorno=0, state=IDLE, dirup=1, tick counter=0.
- pend(f) = flreq[f] | upreq[f] | dnreq[f], with bits 2 of upreq and 0 of dnreq masked.
- above = any pend(f) with f > floorno; below = any pend(f) with f < floorno.
- States: IDLE, MOVE_UP, MOVE_DN, DOOR. All are registered; outputs decode from state/registers with no combinational input-to-output path.
- IDLE exits, evaluated every clk, in priority order:
  - pend(floorno): go to DOOR next clk. Set dirup=1 if upreq[floorno], else 0 if dnreq[floorno], else unchanged.
  - Else dirup & above: go to MOVE_UP.
  - Else below: go to MOVE_DN and set dirup=0.
  - Else above: go to MOVE_UP and set dirup=1.
  - Else stay in IDLE.
- MOVE_UP / MOVE_DN:
  - upsig (resp. dnsig)=1, moving=1, counter cleared on entry.
  - Counter advances only on slowref.
  - On the slowref at which counter==FLOOR_TICKS-1: floorno increments (resp. decrements), counter clears, and the stop test runs on the new floor f.
- Stop test, moving up:
  - Stop if flreq[f] | upreq[f] | f==2 | (dnreq[f] & no pend above f).
  - On stop, if no upreq[f] and nothing pending above f, set dirup=0.
  - Moving down is the mirror: stop if flreq[f] | dnreq[f] | f==0 | (upreq[f] & none below f); flip dirup=1 likewise.
  - Stop: go to DOOR, clearing upsig/dnsig/moving the same clk. Otherwise continue in the same state.
- floorno never leaves 0..2. MOVE_UP is never entered at floor 2, nor MOVE_DN at floor 0.
- DOOR:
  - door_open=1 and clr_flreq[floorno]=1 for the whole state.
  - clrup[floorno]=dirup and clrdn[floorno]=!dirup, masked at floors 2 and 0 respectively.
  - Exits to IDLE on the slowref at which counter==DOOR_TICKS-1. All clears drop on the IDLE clk.
- Requests asserted mid-travel are sampled only at floor arrival or in IDLE.
- A request at the current floor during DOOR is covered by the held clears when it matches dirup. Otherwise it is served by a second DOOR entry from IDLE.
- Reset asserted mid-travel or mid-door returns to the reset values immediately; no partial clear pulse is held.
- Simultaneous up and down calls at the current floor in IDLE: the up call is served first, then the down call via a second DOOR.

Test Plan:
- Setup for all scenarios: FLOOR_TICKS=4, DOOR_TICKS=3, slowref one clk in every 4.
- Reset held 16 clk, then released with no requests -> all outputs 0, floorno=0, stays IDLE for 200 clk.
- flreq=3'b100 at floor 0 -> upsig=moving=1 for 8 ticks; floorno goes 1 at tick 4, 2 at tick 8; then door_open=1 and clr_flreq[2]=1 for 3 ticks; IDLE; release flreq; no further motion.
- flreq=3'b110 from floor 0 -> stop at floor 1 (clr_flreq[1], 3 ticks), then continue up and stop at 2 (clr_flreq[2]).
- At floor 2 with dnreq[1]=1 and upreq[1]=1 -> dnsig 4 ticks, floorno=1, DOOR with clrdn[1]=1 and clrup[1]=0; release dnreq; IDLE; second DOOR with clrup[1]=1; no motion.
- upreq[0]=1 in IDLE at floor 0 -> DOOR next clk, clrup[0]=1, upsig/dnsig stay 0.
- Reset asserted 2 ticks into MOVE_UP from floor 0 -> same clk: moving=0, floorno=0, all clears 0; after release with flreq[1] still set, travel restarts with a full 4-tick count.
